bram_stream_reader: RTL
=======================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 18: BRAM data width.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024: BRAM entries; AW = clog2(RAM_DEPTH).
REQ-003 SHALL have parameter READ_LATENCY, default 2: BRAM read latency in cycles (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY).
REQ-004 SHALL have one clock and a synchronous, active-high reset, as below.
REQ-005 SHALL have port clk_in, input, 1: sole clock.
REQ-006 SHALL have port rst_in, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start_in, input, 1: single-cycle request to begin a burst.
REQ-008 SHALL have port base_addr_in, input, AW: first BRAM address.
REQ-009 SHALL have port length_in, input, AW+1: word count, 0..RAM_DEPTH.
REQ-010 SHALL have port busy_out, output, 1: burst in progress.
REQ-011 SHALL have port done_out, output, 1: one-cycle pulse at burst end.
REQ-012 SHALL have port err_out, output, 1: one-cycle pulse on a rejected start.
REQ-013 SHALL have port addr_out, output, AW: BRAM read-port address.
REQ-014 SHALL have port en_out, output, 1: BRAM port enable.
REQ-015 SHALL have port regce_out, output, 1: BRAM output-register enable.
REQ-016 SHALL have port rdata_in, input, RAM_WIDTH: BRAM read data.
REQ-017 SHALL have port data_out, output, RAM_WIDTH: stream data.
REQ-018 SHALL have port valid_out, output, 1: stream valid.
REQ-019 SHALL have port ready_in, input, 1: stream ready.
REQ-020 SHALL have port last_out, output, 1: marks the final word of a burst.

Function
REQ-021 SHALL implement the states IDLE, ISSUE and DRAIN.
REQ-022 SHALL leave IDLE only on start_in with length_in != 0 and the request accepted; start_in while busy_out=1 SHALL be ignored.
REQ-023 SHALL treat start_in with length_in=0 as no burst: stay IDLE and pulse done_out on the next cycle.
REQ-024 SHALL, in ISSUE, issue one read per cycle (addr_out = base + i) only when outstanding reads plus FIFO occupancy < FIFO_DEPTH.
REQ-025 SHALL stall ISSUE, without dropping data, when ready_in is held low.
REQ-026 SHALL drive en_out = regce_out = 1 whenever state != IDLE.
REQ-027 SHALL track real reads with a READ_LATENCY-deep valid shift register and push rdata_in into the FIFO when its tail bit is set.
REQ-028 SHALL enter DRAIN after the last issue.
REQ-029 SHALL go DRAIN -> IDLE on the cycle the last word handshakes (valid_out & ready_in & last_out), pulsing done_out that same cycle.
REQ-030 SHALL set last_out only with the final word and keep it aligned with that word.
REQ-031 SHALL hold data_out, valid_out and last_out stable while valid_out=1 and ready_in=0.
REQ-032 SHALL sustain throughput of 1 word/cycle when ready_in is held at 1.
REQ-033 SHALL make the first valid_out no earlier than READ_LATENCY+1 cycles after start_in.

Reset
REQ-034 SHALL, when rst_in is high at a clk_in edge, force the state to IDLE, flush the FIFO and clear the valid shift register.
REQ-035 SHALL, during reset, drive valid_out, last_out, busy_out, done_out, err_out, en_out and regce_out to 0, and addr_out and data_out to 0.
REQ-036 SHALL abandon a burst if reset occurs mid-burst: no done_out pulse, and no residual words after reset.

Configuration
REQ-037 SHALL provide macro BRAM_READER_WRAP_EN.
REQ-038 SHALL, when BRAM_READER_WRAP_EN is defined, wrap addresses modulo RAM_DEPTH if base + length exceeds RAM_DEPTH.
REQ-039 SHALL, when BRAM_READER_WRAP_EN is undefined, reject such a start: pulse err_out next cycle, stay IDLE, no done_out.

Structure
REQ-040 SHALL place the state enum, FIFO_DEPTH = READ_LATENCY+2 and the clog2 helper in package bram_reader_pkg.
REQ-041 SHALL implement the output buffer as sub-module bram_reader_fifo (synchronous, first-word-fall-through, depth FIFO_DEPTH).

Verification
REQ-042 SHALL test: base=0x010, len=8, ready=1 -> addrs 0x010..0x017, data matches preload, last_out on word 8, done_out same cycle.
REQ-043 SHALL test: len=16, ready toggling 1/0 every cycle -> 16 words in order, none lost or duplicated, outputs stable while stalled.
REQ-044 SHALL test: base=0x3FE, len=4 -> WRAP_EN: addrs 0x3FE, 0x3FF, 0x000, 0x001; without: err_out pulse, no valid_out.
REQ-045 SHALL test: start with len=0 -> done_out pulse next cycle, valid_out stays 0.
REQ-046 SHALL test: rst_in asserted after 3 of 10 words -> all outputs 0, a new burst (base=0, len=2) then runs cleanly.
REQ-047 SHALL test: start_in re-pulsed mid-burst -> ignored; the original burst completes unchanged.

Source files
------------

// File: rtl/bram_reader_pkg.sv
// rtl/bram_reader_pkg.sv - shared state type, FIFO sizing and clog2 helper for the BRAM stream reader
package bram_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_READ_LATENCY = 2;

  // Reads in flight plus buffered words never exceed this, so one spare slot keeps 1 word/cycle.
  localparam int FIFO_DEPTH = DEFAULT_READ_LATENCY + 2;

  function automatic int fifo_depth(input int read_latency);
    return read_latency + 2;
  endfunction

  // Minimum 1 so that single-entry configurations still get a real vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bram_reader_fifo.sv
// rtl/bram_reader_fifo.sv - synchronous first-word-fall-through output buffer
module bram_reader_fifo
  import bram_reader_pkg::*;
#(
  parameter int  WIDTH = 19,
  parameter int  DEPTH = 4,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en_in,
  input  logic [WIDTH-1:0] wr_data_in,
  input  logic             rd_en_in,
  output logic [WIDTH-1:0] rd_data_out,
  output logic             valid_out,
  output logic [CW-1:0]    count_out
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign w_do_rd     = rd_en_in && (r_count != '0);
  assign w_do_wr     = wr_en_in && ((r_count != CW'(DEPTH)) || w_do_rd);
  assign rd_data_out = r_mem[r_rd_ptr];
  assign valid_out   = (r_count != '0);
  assign count_out   = r_count;

  // Pointer/count bookkeeping and storage write; the head entry is always visible on rd_data_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= wr_data_in;
        r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - burst reader from a BRAM port into a valid/ready stream (option: BRAM_READER_WRAP_EN)
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int  RAM_WIDTH    = 18,
  parameter int  RAM_DEPTH    = 1024,
  parameter int  READ_LATENCY = 2,
  localparam int AW           = clog2(RAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        base_addr_in,
  input  logic [AW:0]          length_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 err_out,
  output logic [AW-1:0]        addr_out,
  output logic                 en_out,
  output logic                 regce_out,
  input  logic [RAM_WIDTH-1:0] rdata_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 last_out
);

  localparam int DEPTH_F = fifo_depth(READ_LATENCY);
  localparam int CW      = clog2(DEPTH_F + 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         w_addr_next;
  logic [AW:0]           r_remaining;
  logic [READ_LATENCY-1:0] r_vsr;
  logic [READ_LATENCY-1:0] r_lsr;
  logic [READ_LATENCY:0] w_vsr_ext;
  logic [READ_LATENCY:0] w_lsr_ext;
  logic                  r_done_zero;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_zero;
  logic                  w_reject;
  logic                  w_range_ok;
  logic                  w_room;
  logic                  w_fifo_valid;
  logic [RAM_WIDTH:0]    w_fifo_rd;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_last_hs;

`ifdef BRAM_READER_WRAP_EN
  assign w_range_ok = 1'b1;
`else
  logic [AW+1:0] w_end;
  assign w_end      = {2'b00, base_addr_in} + {1'b0, length_in};
  assign w_range_ok = (w_end <= (AW+2)'(RAM_DEPTH));
`endif

  // Reads in flight plus buffered words must stay below the FIFO depth so no returning word is dropped.
  assign w_room      = ($countones(r_vsr) + int'(w_fifo_count)) < DEPTH_F;
  assign w_addr_next = (r_addr == AW'(RAM_DEPTH - 1)) ? '0 : r_addr + 1'b1;
  assign w_vsr_ext   = {r_vsr, w_issue};
  assign w_lsr_ext   = {r_lsr, w_issue && (r_remaining == (AW+1)'(1))};

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-cycle accept/issue/reject strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_zero       = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          if (length_in == '0) begin
            w_zero = 1'b1;
          end else if (w_range_ok) begin
            w_accept     = 1'b1;
            w_next_state = S_ISSUE;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_remaining == (AW+1)'(1)) begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_last_hs) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Address/count walk, read-latency tracking and the one-cycle status pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_vsr       <= '0;
      r_lsr       <= '0;
      r_done_zero <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done_zero <= w_zero;
      r_err       <= w_reject;
      r_vsr       <= w_vsr_ext[READ_LATENCY-1:0];
      r_lsr       <= w_lsr_ext[READ_LATENCY-1:0];
      if (w_accept) begin
        r_addr      <= base_addr_in;
        r_remaining <= length_in;
      end else if (w_issue) begin
        r_addr      <= w_addr_next;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  bram_reader_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (DEPTH_F)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en_in    (r_vsr[READ_LATENCY-1]),
    .wr_data_in  ({r_lsr[READ_LATENCY-1], rdata_in}),
    .rd_en_in    (w_pop),
    .rd_data_out (w_fifo_rd),
    .valid_out   (w_fifo_valid),
    .count_out   (w_fifo_count)
  );

  assign w_valid   = w_fifo_valid & ~rst_in;
  assign w_pop     = w_valid & ready_in;
  assign w_last_hs = w_pop & w_fifo_rd[RAM_WIDTH];

  assign valid_out = w_valid;
  assign last_out  = w_valid & w_fifo_rd[RAM_WIDTH];
  assign data_out  = w_valid ? w_fifo_rd[RAM_WIDTH-1:0] : '0;
  assign done_out  = ~rst_in & (w_last_hs | r_done_zero);
  assign err_out   = ~rst_in & r_err;
  assign busy_out  = ~rst_in & (r_state != S_IDLE);
  assign en_out    = busy_out;
  assign regce_out = busy_out;
  assign addr_out  = rst_in ? '0 : r_addr;

endmodule
